// File: rtl/dll_tx_framer.sv
// Transmit framer: header + BURST payload words + trailer check word on a valid/ready link.
// Define DLL_CRC12_EN to make the trailer a CRC-12 (0x80F) instead of the XOR of the payload.
module dll_tx_framer #(
  parameter int unsigned BURST  = 4,
  parameter logic [3:0]  MARKER = 4'hA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [11:0] fifo_data,
  output logic        fifo_pop,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [11:0] tx_data,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic [7:0]  seq_num,
  output logic [15:0] frames_sent
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    TRAILER = 2'd3
  } state_t;

  localparam logic [3:0] LAST = 4'(BURST - 1);

  state_t      state, state_nxt;
  logic [3:0]  count;
  logic [11:0] acc;
  logic        ld;
  logic        load;
  logic [11:0] load_data;
  logic        load_sop;
  logic        load_eop;

  function automatic logic [11:0] check_step(input logic [11:0] a, input logic [11:0] d);
`ifdef DLL_CRC12_EN
    logic [11:0] c;
    logic        fb;
    c = a;
    for (int i = 11; i >= 0; i--) begin
      fb = c[11] ^ d[i];
      c  = {c[10:0], 1'b0};
      if (fb) c = c ^ 12'h80F;
    end
    return c;
`else
    return a ^ d;
`endif
  endfunction

  assign ld = !tx_valid || tx_ready;

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    load_data = tx_data;
    load_sop  = 1'b0;
    load_eop  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) state_nxt = HDR;
      end
      HDR: begin
        if (ld) begin
          load      = 1'b1;
          load_data = {MARKER, seq_num};
          load_sop  = 1'b1;
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // Reset gates the pop so a word is never taken from the FIFO during reset.
        if (ld && !fifo_empty && !reset) begin
          fifo_pop  = 1'b1;
          load      = 1'b1;
          load_data = fifo_data;
          if (count == LAST) state_nxt = TRAILER;
        end
      end
      TRAILER: begin
        if (ld) begin
          load      = 1'b1;
          load_data = acc;
          load_eop  = 1'b1;
          state_nxt = (enable && !fifo_empty) ? HDR : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= 12'h000;
      tx_sop      <= 1'b0;
      tx_eop      <= 1'b0;
      seq_num     <= 8'h00;
      frames_sent <= 16'h0000;
      count       <= 4'd0;
      acc         <= 12'h000;
    end else begin
      state <= state_nxt;
      if (load) begin
        tx_valid <= 1'b1;
        tx_data  <= load_data;
        tx_sop   <= load_sop;
        tx_eop   <= load_eop;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (state == HDR && ld) begin
        acc   <= 12'h000;
        count <= 4'd0;
      end else if (fifo_pop) begin
        acc   <= check_step(acc, fifo_data);
        count <= count + 4'd1;
      end
      if (state == TRAILER && ld) seq_num <= seq_num + 8'd1;
      if (tx_valid && tx_ready && tx_eop && frames_sent != 16'hFFFF)
        frames_sent <= frames_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_dll_tx_framer.sv
// Directed bench for dll_tx_framer: FIFO model feeds the DUT, accepted beats are logged and checked.
// Honours DLL_CRC12_EN when computing expected trailers.
module tb_dll_tx_framer;

  localparam logic [3:0] MARKER = 4'hA;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic [11:0] fifo_data;
  logic        fifo_pop;
  logic        tx_ready;
  logic        tx_valid;
  logic [11:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic [7:0]  seq_num;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;

  logic [11:0] fifo_mem [0:2047];
  int rd = 0;
  int wr = 0;
  int pop_count = 0;

  logic [11:0] beat_data [0:4095];
  logic        beat_sop  [0:4095];
  logic        beat_eop  [0:4095];
  int          beat_cyc  [0:4095];
  int          beat_n = 0;
  int          cyc = 0;

  int base;

  always #5 clk = ~clk;

  dll_tx_framer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .seq_num(seq_num), .frames_sent(frames_sent)
  );

  assign fifo_empty = (rd == wr);
  assign fifo_data  = fifo_mem[rd[10:0]];

  always @(posedge clk) begin
    if (fifo_pop) begin
      rd        <= rd + 1;
      pop_count <= pop_count + 1;
    end
  end

  // Every accepted beat (outside reset) goes into the log with its cycle number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && tx_valid && tx_ready) begin
      beat_data[beat_n] <= tx_data;
      beat_sop[beat_n]  <= tx_sop;
      beat_eop[beat_n]  <= tx_eop;
      beat_cyc[beat_n]  <= cyc;
      beat_n            <= beat_n + 1;
    end
  end

  function automatic logic [11:0] word_at(input int k);
    return 12'(k * 37 + 5);
  endfunction

  // Reference trailer; the CRC is computed as long division of msg * x^12 by the polynomial.
  function automatic logic [11:0] model_check(input logic [47:0] msg);
`ifdef DLL_CRC12_EN
    logic [59:0] r;
    r = {msg, 12'h000};
    for (int i = 59; i >= 12; i--) begin
      if (r[i]) r[i -: 13] = r[i -: 13] ^ 13'h180F;
    end
    return r[11:0];
`else
    return msg[47:36] ^ msg[35:24] ^ msg[23:12] ^ msg[11:0];
`endif
  endfunction

  function automatic logic [47:0] frame_msg(input int f);
    return {word_at(4 * f), word_at(4 * f + 1), word_at(4 * f + 2), word_at(4 * f + 3)};
  endfunction

  task automatic push(input logic [11:0] w);
    fifo_mem[wr[10:0]] = w;
    wr = wr + 1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int b, input logic [7:0] seq,
                             input logic [47:0] msg);
    check_output({tag, " hdr"}, 32'(beat_data[b]), 32'({MARKER, seq}));
    check_output({tag, " sop"}, 32'(beat_sop[b]), 32'd1);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("%s pl%0d", tag, i), 32'(beat_data[b + 1 + i]),
                   32'(msg[47 - 12 * i -: 12]));
    check_output({tag, " trl"}, 32'(beat_data[b + 5]), 32'(model_check(msg)));
    check_output({tag, " eop"}, 32'(beat_eop[b + 5]), 32'd1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget && int'(frames_sent) != target; i++) @(negedge clk);
    check_output("frames_sent", 32'(frames_sent), 32'(target));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    tx_ready = 1'b1;
    push(12'h001); push(12'h002); push(12'h003); push(12'h004);
    repeat (2) @(negedge clk);
    check_output("rst tx_valid", 32'(tx_valid), 32'd0);
    check_output("rst tx_data", 32'(tx_data), 32'd0);
    check_output("rst tx_sop", 32'(tx_sop), 32'd0);
    check_output("rst tx_eop", 32'(tx_eop), 32'd0);
    check_output("rst seq_num", 32'(seq_num), 32'd0);
    check_output("rst frames_sent", 32'(frames_sent), 32'd0);
    check_output("rst fifo_pop", 32'(fifo_pop), 32'd0);
    check_output("rst state", 32'(dut.state), 32'd0);

    // Basic frame and header latency.
    enable = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    check_output("lat state hdr", 32'(dut.state), 32'd1);
    check_output("lat valid0", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check_output("lat valid1", 32'(tx_valid), 32'd1);
    check_output("lat hdr", 32'(tx_data), 32'h0A00);
    check_output("lat sop", 32'(tx_sop), 32'd1);
    wait_frames(1, 50);
    check_frame("f1", 0, 8'h00, {12'h001, 12'h002, 12'h003, 12'h004});
    check_output("f1 seq_num", 32'(seq_num), 32'd1);
    check_output("f1 pops", 32'(pop_count), 32'd4);

    // Backpressure while 002 is on the link.
    base = beat_n;
    push(12'h001); push(12'h002); push(12'h003); push(12'h004);
    for (int i = 0; i < 20 && !(tx_valid && tx_data == 12'h002); i++) @(negedge clk);
    check_output("bp reach 002", 32'(tx_data), 32'h002);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output($sformatf("bp data %0d", i), 32'(tx_data), 32'h002);
      check_output($sformatf("bp valid %0d", i), 32'(tx_valid), 32'd1);
      check_output($sformatf("bp pop %0d", i), 32'(fifo_pop), 32'd0);
      @(negedge clk);
    end
    tx_ready = 1'b1;
    wait_frames(2, 50);
    check_frame("f2", base, 8'h01, {12'h001, 12'h002, 12'h003, 12'h004});
    check_output("f2 pops", 32'(pop_count), 32'd8);

    // FIFO underrun after two payload words.
    base = beat_n;
    push(12'h001); push(12'h002);
    for (int i = 0; i < 20 && !(tx_valid && tx_data == 12'h002); i++) @(negedge clk);
    check_output("ur reach 002", 32'(tx_data), 32'h002);
    @(negedge clk);
    check_output("ur valid", 32'(tx_valid), 32'd0);
    check_output("ur state", 32'(dut.state), 32'd2);
    check_output("ur count", 32'(dut.count), 32'd2);
    repeat (4) @(negedge clk);
    check_output("ur hold state", 32'(dut.state), 32'd2);
    check_output("ur hold valid", 32'(tx_valid), 32'd0);
    push(12'h003); push(12'h004);
    wait_frames(3, 50);
    check_frame("f3", base, 8'h02, {12'h001, 12'h002, 12'h003, 12'h004});

    // Reset on the third payload beat; remaining words form a fresh frame.
    for (int k = 1; k <= 7; k++) push(12'(k));
    for (int i = 0; i < 20 && !(tx_valid && tx_data == 12'h003 && !tx_sop); i++) @(negedge clk);
    check_output("mr reach 003", 32'(tx_data), 32'h003);
    reset = 1'b1;
    @(negedge clk);
    check_output("mr valid", 32'(tx_valid), 32'd0);
    check_output("mr seq_num", 32'(seq_num), 32'd0);
    check_output("mr frames", 32'(frames_sent), 32'd0);
    check_output("mr state", 32'(dut.state), 32'd0);
    check_output("mr pop", 32'(fifo_pop), 32'd0);
    reset = 1'b0;
    base  = beat_n;
    wait_frames(1, 50);
    check_frame("mr new", base, 8'h00, {12'h004, 12'h005, 12'h006, 12'h007});
    check_output("mr fifo drained", 32'(fifo_empty), 32'd1);

    // 256 back-to-back frames, then one more to see the sequence wrap.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 1024; k++) push(word_at(k));
    base = beat_n;
    wait_frames(256, 2000);
    check_output("b2b seq wrap", 32'(seq_num), 32'd0);
    check_frame("b2b first", base, 8'h00, frame_msg(0));
    check_frame("b2b f256", base + 255 * 6, 8'hFF, frame_msg(255));
    check_output("b2b contiguous", 32'(beat_cyc[base + 1535] - beat_cyc[base]), 32'd1535);
    for (int k = 1024; k < 1028; k++) push(word_at(k));
    wait_frames(257, 50);
    check_frame("b2b wrap hdr", base + 1536, 8'h00, frame_msg(256));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
